// File: rtl/psram_rx_deser.sv
// rtl/psram_rx_deser.sv - PSRAM SO-line deserializer: skips the cmd/addr/dummy window, packs MSB-first bytes into a FIFO
// Optional: define PSRAM_RX_CHECKSUM_EN to add the rx_csum XOR-of-bytes output.
module psram_rx_deser #(
    parameter int SKIP_W     = 8,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic              start,
    input  logic [SKIP_W-1:0] skip_bits,
    input  logic [LEN_W-1:0]  byte_count,
    input  logic              ce_n,
    input  logic              sdi,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              overflow
`ifdef PSRAM_RX_CHECKSUM_EN
    ,
    output logic [7:0]        rx_csum
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SKIP = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic              ce_n_q, ce_n_d;
    logic              zero_done_q, zero_done_d;
    logic              aborted_q, aborted_d;
    logic              overflow_q, overflow_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
`ifdef PSRAM_RX_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic       sample;
    logic       ce_rise;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       fifo_full;
    logic       fifo_pop;
    logic       push_ok;

    // Capture FSM, bit/byte packing, FIFO pointer and sticky-flag updates
    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ce_n_d      = ce_n;
        zero_done_d = 1'b0;
        aborted_d   = aborted_q;
        overflow_d  = overflow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
`ifdef PSRAM_RX_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        byte_valid  = 1'b0;
        byte_data   = {shift_q, sdi};

        // The chip clock only runs while selected, so only those edges carry bits
        sample  = ((state_q == S_SKIP) || (state_q == S_DATA)) && !ce_n;
        // A deselect while bits are still owed means the command engine gave up
        ce_rise = ce_n && !ce_n_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (byte_count != '0) begin
                        skip_cnt_d = skip_bits;
                        byte_cnt_d = byte_count;
                        bit_cnt_d  = 3'd0;
                        shift_d    = 7'd0;
                        aborted_d  = 1'b0;
                        overflow_d = 1'b0;
`ifdef PSRAM_RX_CHECKSUM_EN
                        csum_d     = 8'd0;
`endif
                        state_d    = (skip_bits != '0) ? S_SKIP : S_DATA;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            S_SKIP: begin
                if (ce_rise) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (sample) begin
                    skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                    if (skip_cnt_q == SKIP_W'(1)) begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (ce_rise) begin
                    // Partial byte is thrown away; FIFO contents stay
                    aborted_d = 1'b1;
                    bit_cnt_d = 3'd0;
                    state_d   = S_IDLE;
                end else if (sample) begin
                    shift_d   = {shift_q[5:0], sdi};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_valid = 1'b1;
                        byte_cnt_d = byte_cnt_q - LEN_W'(1);
                        if (byte_cnt_q == LEN_W'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        fifo_pop  = (wr_ptr_q != rd_ptr_q) && out_ready;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands
        push_ok   = byte_valid && (!fifo_full || fifo_pop);

        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = byte_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (byte_valid && !push_ok) begin
            overflow_d = 1'b1;
        end
`ifdef PSRAM_RX_CHECKSUM_EN
        // Dropped bytes still count: the checksum reflects what the chip sent
        if (byte_valid) begin
            csum_d = csum_q ^ byte_data;
        end
`endif
    end

    // State and datapath registers; reset discards everything without pulses
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q     <= S_IDLE;
            skip_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            ce_n_q      <= 1'b1;
            zero_done_q <= 1'b0;
            aborted_q   <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
`ifdef PSRAM_RX_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ce_n_q      <= ce_n_d;
            zero_done_q <= zero_done_d;
            aborted_q   <= aborted_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
`ifdef PSRAM_RX_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = (wr_ptr_q != rd_ptr_q);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) || zero_done_q;
    assign aborted   = aborted_q;
    assign overflow  = overflow_q;
`ifdef PSRAM_RX_CHECKSUM_EN
    assign rx_csum   = csum_q;
`endif

endmodule

// File: tb/tb_psram_rx_deser.sv
// tb/tb_psram_rx_deser.sv - directed self-checking bench for psram_rx_deser
module tb_psram_rx_deser;

    logic       sys_clk = 1'b0;
    logic       sys_reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] skip_bits = 8'd0;
    logic [7:0] byte_count = 8'd0;
    logic       ce_n = 1'b1;
    logic       sdi = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       overflow;
`ifdef PSRAM_RX_CHECKSUM_EN
    logic [7:0] rx_csum;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] rxq[$];
    int done_cnt = 0;

    psram_rx_deser #(.SKIP_W(8), .LEN_W(8), .FIFO_DEPTH(4)) dut (
        .sys_clk(sys_clk),
        .sys_reset_n(sys_reset_n),
        .start(start),
        .skip_bits(skip_bits),
        .byte_count(byte_count),
        .ce_n(ce_n),
        .sdi(sdi),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .overflow(overflow)
`ifdef PSRAM_RX_CHECKSUM_EN
        ,
        .rx_csum(rx_csum)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Record delivered bytes and done pulses between edges
    always @(negedge sys_clk) begin
        #2;
        if (out_valid && out_ready) rxq.push_back(out_data);
        if (done) done_cnt++;
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic clear_mon();
        rxq.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [7:0] sk, input logic [7:0] cnt);
        start = 1'b1;
        skip_bits = sk;
        byte_count = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        ce_n = 1'b0;
        sdi = b;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_q(input string name, input logic [7:0] exp[$]);
        n_checks++;
        if (rxq.size() != exp.size()) begin
            n_fail++;
            $display("FAIL %s: got %0d bytes, expected %0d", name, rxq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                if (rxq[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %02h, expected %02h", name, i, rxq[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL reset_aborted: got %b expected 0", aborted); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h expected 00", out_data); end
    endtask

    task automatic test_read_id();
        logic [31:0] hdr;
        hdr = 32'h9F00_C3A7;
        out_ready = 1'b1;
        clear_mon();
        do_start(8'd32, 8'd3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rid_busy: got %b expected 1", busy); end
        for (int i = 31; i >= 0; i--) send_bit(hdr[i]);
        send_byte(8'h0D);
        send_byte(8'h5D);
        send_byte(8'h52);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rid_done: got %b expected 1", done); end
        ce_n = 1'b1;
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rid_done_width: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rid_idle: got %b expected 0", busy); end
        repeat (4) tick();
        check_q("rid_bytes", '{8'h0D, 8'h5D, 8'h52});
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rid_done_cnt: got %0d expected 1", done_cnt); end
        n_checks++; if (aborted !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rid_flags: got %b%b expected 00", aborted, overflow); end
`ifdef PSRAM_RX_CHECKSUM_EN
        n_checks++; if (rx_csum !== 8'h02) begin n_fail++; $display("FAIL rid_csum: got %02h expected 02", rx_csum); end
`endif
    endtask

    task automatic test_zero_skip();
        clear_mon();
        do_start(8'd0, 8'd2);
        send_byte(8'hA5);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zs_early_done: got %b expected 0", done); end
        send_byte(8'h3C);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zs_done: got %b expected 1", done); end
        ce_n = 1'b1;
        repeat (4) tick();
        check_q("zs_bytes", '{8'hA5, 8'h3C});
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL zs_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_zero_count();
        clear_mon();
        do_start(8'd5, 8'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zc_done: got %b expected 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zc_busy: got %b expected 0", busy); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zc_done_width: got %b expected 0", done); end
    endtask

    task automatic test_gated_clock();
        clear_mon();
        ce_n = 1'b1;
        do_start(8'd4, 8'd1);
        sdi = 1'b1;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b1 || aborted !== 1'b0) begin n_fail++; $display("FAIL gc_hold: busy %b aborted %b expected 1 0", busy, aborted); end
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_byte(8'hF0);
        ce_n = 1'b1;
        repeat (4) tick();
        check_q("gc_bytes", '{8'hF0});
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL gc_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_overflow();
        clear_mon();
        out_ready = 1'b0;
        do_start(8'd0, 8'd6);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ov_early: got %b expected 0", overflow); end
        send_byte(8'h55);
        send_byte(8'h66);
        ce_n = 1'b1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ov_done: got %b expected 1", done); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ov_flag: got %b expected 1", overflow); end
        n_checks++; if (out_valid !== 1'b1 || rxq.size() != 0) begin n_fail++; $display("FAIL ov_held: valid %b popped %0d expected 1 0", out_valid, rxq.size()); end
        out_ready = 1'b1;
        repeat (8) tick();
        check_q("ov_bytes", '{8'h11, 8'h22, 8'h33, 8'h44});
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ov_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_abort();
        clear_mon();
        out_ready = 1'b0;
        do_start(8'd0, 8'd4);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ab_ov_clear: got %b expected 0", overflow); end
        send_byte(8'h81);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ce_n = 1'b1;
        tick();
        n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL ab_flag: got %b expected 1", aborted); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %b expected 0", busy); end
        repeat (3) tick();
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL ab_no_done: got %0d expected 0", done_cnt); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h81) begin n_fail++; $display("FAIL ab_fifo: valid %b data %02h expected 1 81", out_valid, out_data); end
        out_ready = 1'b1;
        repeat (3) tick();
        check_q("ab_bytes", '{8'h81});
        do_start(8'd0, 8'd1);
        n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL ab_clear: got %b expected 0", aborted); end
    endtask

    task automatic test_busy_start();
        logic [7:0] b;
        b = 8'h5A;
        clear_mon();
        for (int i = 7; i >= 5; i--) send_bit(b[i]);
        start = 1'b1;
        skip_bits = 8'd3;
        byte_count = 8'd7;
        send_bit(b[4]);
        start = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(b[i]);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bs_done: got %b expected 1", done); end
        ce_n = 1'b1;
        repeat (4) tick();
        check_q("bs_bytes", '{8'h5A});
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bs_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        out_ready = 1'b0;
        do_start(8'd0, 8'd2);
        send_byte(8'hC7);
        send_bit(1'b1);
        send_bit(1'b0);
        n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rm_pre: valid %b busy %b expected 1 1", out_valid, busy); end
        sys_reset_n = 1'b0;
        tick();
        sys_reset_n = 1'b1;
        ce_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
        n_checks++; if (aborted !== 1'b0 || overflow !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rm_flags: got %b%b%b expected 000", aborted, overflow, done); end
        repeat (3) tick();
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rm_no_done: got %0d expected 0", done_cnt); end
`ifdef PSRAM_RX_CHECKSUM_EN
        n_checks++; if (rx_csum !== 8'h00) begin n_fail++; $display("FAIL rm_csum: got %02h expected 00", rx_csum); end
`endif
    endtask

    initial begin
        tick();
        tick();
        sys_reset_n = 1'b1;
        tick();
        test_reset();
        test_read_id();
        test_zero_skip();
        test_zero_count();
        test_gated_clock();
        test_overflow();
        test_abort();
        test_busy_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
